// File: rtl/slow_queue_fir_reader.sv
// FIR consumer of the slow circular sample queue: multiplies each burst sample by a
// ROM coefficient, accumulates the burst and emits one saturated 16-bit result per burst.
module slow_queue_fir_reader #(
    parameter int N_TAPS = 1021,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sequencing,
    input  logic signed [15:0]       smpl_in,
    output logic        [ADDR_W-1:0] coeff_addr,
    input  logic signed [15:0]       coeff,
    output logic signed [15:0]       filt_out,
    output logic                     filt_vld,
    output logic                     tap_err
);

    localparam int CNT_W = $clog2(N_TAPS + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_TAPS);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(N_TAPS + 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FLUSH  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // armed remembers that sequencing was low last cycle, so only a true rising edge
    // starts a burst; it resets low so a burst interrupted by reset stays ignored.
    logic                     armed;
    logic signed [15:0]       dly_smpl;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  tap_cnt;

    logic        [ADDR_W-1:0] addr_nxt;
    logic signed [15:0]       dly_nxt;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic        [CNT_W-1:0]  cnt_nxt;
    logic signed [15:0]       out_nxt;
    logic                     vld_nxt;
    logic                     err_nxt;

    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [15:0]       acc_sat;
    logic                     start;

    assign start   = sequencing && armed;
    assign prod    = dly_smpl * coeff;
    assign term    = ACC_W'(prod >>> 15);
    assign acc_sum = acc + term;

    always_comb begin
        if (acc > SAT_HI) begin
            acc_sat = 16'sh7FFF;
        end else if (acc < SAT_LO) begin
            acc_sat = 16'sh8000;
        end else begin
            acc_sat = acc[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (!sequencing) state_nxt = FLUSH;
            FLUSH:   state_nxt = RESULT;
            RESULT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The sample delay register trails coeff_addr by one cycle, matching the ROM latency,
    // so the product formed in ACCUM always pairs sample i with coefficient i.
    always_comb begin
        addr_nxt = coeff_addr;
        dly_nxt  = dly_smpl;
        acc_nxt  = acc;
        cnt_nxt  = tap_cnt;
        out_nxt  = filt_out;
        vld_nxt  = 1'b0;
        err_nxt  = tap_err;
        case (state)
            IDLE: begin
                addr_nxt = '0;
                if (start) begin
                    acc_nxt  = '0;
                    err_nxt  = 1'b0;
                    dly_nxt  = smpl_in;
                    addr_nxt = ADDR_W'(1);
                    cnt_nxt  = CNT_W'(1);
                end
            end
            ACCUM: begin
                acc_nxt = acc_sum;
                if (sequencing) begin
                    dly_nxt  = smpl_in;
                    cnt_nxt  = (tap_cnt == CNT_SAT) ? tap_cnt : tap_cnt + CNT_W'(1);
                    addr_nxt = (coeff_addr == LAST_ADDR) ? coeff_addr
                                                         : coeff_addr + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (tap_cnt == CNT_FULL) begin
                    out_nxt = acc_sat;
                    vld_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
                if (sequencing) err_nxt = 1'b1;
            end
            RESULT: begin
                addr_nxt = '0;
                if (sequencing) err_nxt = 1'b1;
            end
            default: begin
                addr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_addr <= '0;
            dly_smpl   <= '0;
            acc        <= '0;
            tap_cnt    <= '0;
            filt_out   <= '0;
            filt_vld   <= 1'b0;
            tap_err    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            coeff_addr <= addr_nxt;
            dly_smpl   <= dly_nxt;
            acc        <= acc_nxt;
            tap_cnt    <= cnt_nxt;
            filt_out   <= out_nxt;
            filt_vld   <= vld_nxt;
            tap_err    <= err_nxt;
            armed      <= !sequencing;
        end
    end

endmodule

// File: tb/tb_slow_queue_fir_reader.sv
// Self-checking bench: a 4-tap and a default 1021-tap reader, each fed from a behavioural
// ROM, compared against an arithmetic model of the burst filter.
module tb_slow_queue_fir_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              seq_s, vld_s, err_s;
    logic signed [15:0] smpl_s, coeff_s, out_s;
    logic        [1:0]  addr_s;
    logic              seq_b, vld_b, err_b;
    logic signed [15:0] smpl_b, coeff_b, out_b;
    logic        [9:0]  addr_b;

    logic signed [15:0] rom_s [0:3];
    logic signed [15:0] rom_b [0:1023];

    always @(posedge clk) coeff_s <= rom_s[addr_s];
    always @(posedge clk) coeff_b <= rom_b[addr_b];

    slow_queue_fir_reader #(.N_TAPS(4), .ADDR_W(2), .ACC_W(30)) u_small (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_s), .smpl_in(smpl_s),
        .coeff_addr(addr_s), .coeff(coeff_s), .filt_out(out_s),
        .filt_vld(vld_s), .tap_err(err_s)
    );

    slow_queue_fir_reader u_big (
        .clk(clk), .rst_n(rst_n), .sequencing(seq_b), .smpl_in(smpl_b),
        .coeff_addr(addr_b), .coeff(coeff_b), .filt_out(out_b),
        .filt_vld(vld_b), .tap_err(err_b)
    );

    int errors = 0;
    int checks = 0;

    bit                 drv_seq [$];
    logic signed [15:0] drv_smp [$];
    logic               obs_vld [$];
    logic        [15:0] obs_out [$];
    logic               obs_err [$];
    int                 obs_addr [$];
    int                 exp_k [$];
    int                 exp_v [$];

    function automatic logic [31:0] w16(input int v);
        return {16'h0, v[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Filter model: sum of floor(sample*coeff / 2^15), then clip to 16-bit signed.
    function automatic int modelFilter(input bit big, input int s[$]);
        longint sum = 0;
        int ntaps = big ? 1021 : 4;
        for (int i = 0; i < s.size(); i++) begin
            int idx = (i < ntaps) ? i : ntaps - 1;
            int c = big ? int'(rom_b[idx]) : int'(rom_s[idx]);
            longint p = longint'(s[i]) * longint'(c);
            longint t = p / 32768;
            if ((p % 32768) != 0 && p < 0) t = t - 1;
            sum += t;
        end
        if (sum > 32767) return 32767;
        if (sum < -32768) return -32768;
        return int'(sum);
    endfunction

    // mode 0: constant base, 1: random full range, 2: ramp 0..len-1, 3: small random
    task automatic pushBurst(input bit big, input int len, input int mode, input int base,
                             output int expv);
        int vals [$];
        for (int i = 0; i < len; i++) begin
            logic signed [15:0] v;
            case (mode)
                0:       v = base[15:0];
                1:       v = 16'($urandom());
                2:       v = 16'(i);
                default: v = 16'(int'($urandom_range(0, 60)) - 30);
            endcase
            drv_seq.push_back(1'b1);
            drv_smp.push_back(v);
            vals.push_back(int'(v));
        end
        expv = modelFilter(big, vals);
    endtask

    task automatic pushLow(input int n);
        for (int i = 0; i < n; i++) begin
            drv_seq.push_back(1'b0);
            drv_smp.push_back(16'sd0);
        end
    endtask

    task automatic applyStimulus(input bit big, input int tail);
        int n = drv_seq.size();
        obs_vld.delete(); obs_out.delete(); obs_err.delete(); obs_addr.delete();
        for (int k = 0; k < n + tail; k++) begin
            @(negedge clk);
            if (big) begin
                obs_vld.push_back(vld_b); obs_out.push_back(out_b);
                obs_err.push_back(err_b); obs_addr.push_back(int'(addr_b));
            end else begin
                obs_vld.push_back(vld_s); obs_out.push_back(out_s);
                obs_err.push_back(err_s); obs_addr.push_back(int'(addr_s));
            end
            seq_s = 1'b0; smpl_s = '0; seq_b = 1'b0; smpl_b = '0;
            if (k < n) begin
                if (big) begin seq_b = drv_seq[k]; smpl_b = drv_smp[k]; end
                else     begin seq_s = drv_seq[k]; smpl_s = drv_smp[k]; end
            end
        end
        drv_seq.delete(); drv_smp.delete();
    endtask

    task automatic expectPulse(input int k, input int v);
        exp_k.push_back(k);
        exp_v.push_back(v);
    endtask

    task automatic checkPulses(input string tag);
        int got_k [$];
        for (int k = 0; k < obs_vld.size(); k++)
            if (obs_vld[k] === 1'b1) got_k.push_back(k);
        checkOutput({tag, "_npulse"}, got_k.size(), exp_k.size());
        for (int i = 0; i < exp_k.size() && i < got_k.size(); i++) begin
            checkOutput({tag, "_pulse_cycle"}, got_k[i], exp_k[i]);
            checkOutput({tag, "_pulse_value"}, {16'h0, obs_out[got_k[i]]}, w16(exp_v[i]));
        end
        exp_k.delete(); exp_v.delete();
    endtask

    task automatic checkFinal(input string tag, input int out_exp, input bit err_exp);
        checkOutput({tag, "_out"}, {16'h0, obs_out[obs_out.size()-1]}, w16(out_exp));
        checkOutput({tag, "_err"}, {31'h0, obs_err[obs_err.size()-1]}, {31'h0, err_exp});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e, e2, prev_s, len, cnt;

        rst_n = 1'b0;
        seq_s = 1'b0; smpl_s = '0; seq_b = 1'b0; smpl_b = '0;
        for (int i = 0; i < 4; i++) rom_s[i] = 16'sh4000;
        for (int i = 0; i < 1024; i++) rom_b[i] = 16'sh7FFF;

        // Reset held with sequencing toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_out_s", {16'h0, out_s}, 32'h0);
            checkOutput("rst_vld_s", {31'h0, vld_s}, 32'h0);
            checkOutput("rst_err_s", {31'h0, err_s}, 32'h0);
            checkOutput("rst_addr_s", {30'h0, addr_s}, 32'h0);
            checkOutput("rst_out_b", {16'h0, out_b}, 32'h0);
            checkOutput("rst_addr_b", {22'h0, addr_b}, 32'h0);
            seq_s = ~seq_s; seq_b = ~seq_b; smpl_s = 16'($urandom()); smpl_b = 16'($urandom());
        end
        @(negedge clk);
        seq_s = 1'b0; seq_b = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Basic 4-tap burst
        pushBurst(0, 4, 0, 16'h1000, e);
        applyStimulus(0, 6);
        for (int k = 0; k <= 4; k++)
            checkOutput("t2_addr", obs_addr[k], (k < 3) ? k : 3);
        expectPulse(6, e);
        checkPulses("t2");
        checkFinal("t2", 16'h2000, 1'b0);
        prev_s = e;

        // Clipping both ways
        for (int i = 0; i < 4; i++) rom_s[i] = 16'sh7FFF;
        pushBurst(0, 4, 0, 16'h7FFF, e);
        applyStimulus(0, 6);
        expectPulse(6, e);
        checkPulses("t3_pos");
        checkFinal("t3_pos", 32767, 1'b0);
        pushBurst(0, 4, 0, 16'h8000, e);
        applyStimulus(0, 6);
        expectPulse(6, e);
        checkPulses("t3_neg");
        checkFinal("t3_neg", -32768, 1'b0);
        prev_s = e;

        // Random coefficients, samples and burst lengths
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) rom_s[i] = 16'($urandom());
            len = int'($urandom_range(2, 6));
            pushBurst(0, len, 1, 0, e);
            applyStimulus(0, 6);
            if (len == 4) begin
                expectPulse(6, e);
                prev_s = e;
            end
            checkPulses("rand");
            checkFinal("rand", prev_s, len != 4);
        end

        // Short, long, then good burst
        for (int i = 0; i < 4; i++) rom_s[i] = 16'sh4000;
        pushBurst(0, 3, 0, 16'h1000, e);
        applyStimulus(0, 6);
        checkPulses("t4_short");
        checkFinal("t4_short", prev_s, 1'b1);
        pushBurst(0, 5, 1, 0, e);
        applyStimulus(0, 6);
        for (int k = 0; k <= 5; k++)
            checkOutput("t4_long_addr", obs_addr[k], (k < 3) ? k : 3);
        checkPulses("t4_long");
        checkFinal("t4_long", prev_s, 1'b1);
        pushBurst(0, 4, 1, 0, e);
        applyStimulus(0, 6);
        checkOutput("t4_err_cleared", {31'h0, obs_err[1]}, 32'h0);
        expectPulse(6, e);
        checkPulses("t4_good");
        checkFinal("t4_good", e, 1'b0);
        prev_s = e;

        // Burst rising while the previous result is flushing is ignored
        pushBurst(0, 4, 1, 0, e);
        pushLow(1);
        pushBurst(0, 4, 1, 0, e2);
        applyStimulus(0, 8);
        expectPulse(6, e);
        checkPulses("coincide");
        checkFinal("coincide", e, 1'b1);

        // Reset asserted during tap 2, released while sequencing is still high
        @(negedge clk); seq_s = 1'b1; smpl_s = 16'h1000;
        @(negedge clk); smpl_s = 16'h1000;
        @(negedge clk); smpl_s = 16'h1000; rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_out", {16'h0, out_s}, 32'h0);
        checkOutput("t5_rst_vld", {31'h0, vld_s}, 32'h0);
        checkOutput("t5_rst_err", {31'h0, err_s}, 32'h0);
        checkOutput("t5_rst_addr", {30'h0, addr_s}, 32'h0);
        smpl_s = 16'h1000; rst_n = 1'b1;
        @(negedge clk); seq_s = 1'b0; smpl_s = '0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vld_s === 1'b1) cnt++;
        end
        checkOutput("t5_no_pulse", cnt, 0);
        checkOutput("t5_out_after", {16'h0, out_s}, 32'h0);
        checkOutput("t5_err_after", {31'h0, err_s}, 32'h0);
        pushBurst(0, 4, 0, 16'h1000, e);
        applyStimulus(0, 6);
        expectPulse(6, e);
        checkPulses("t5_clean");
        checkFinal("t5_clean", 16'h2000, 1'b0);

        // Default depth: ramp burst then a back-to-back random burst 3 low cycles later
        pushBurst(1, 1021, 2, 0, e);
        pushLow(3);
        pushBurst(1, 1021, 3, 0, e2);
        applyStimulus(1, 6);
        checkOutput("t6_addr_1", obs_addr[1], 1);
        checkOutput("t6_addr_500", obs_addr[500], 500);
        checkOutput("t6_addr_1020", obs_addr[1020], 1020);
        checkOutput("t6_addr_1021", obs_addr[1021], 1020);
        expectPulse(1023, e);
        expectPulse(2047, e2);
        checkPulses("t6");
        checkOutput("t6_first_out", {16'h0, obs_out[1023]}, 32'h7FFF);
        checkFinal("t6", e2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
